// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator: FSM encodings, opcodes
// and the two's-complement overflow rule used on the core result.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow from operand and result sign bits. A subtract is an add
    // of ~B, so its operands must differ in sign for the result to overflow.
    function automatic logic ovf_detect(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic op
    );
        logic same_sign;
        same_sign = (op == OP_ADD) ? (a_msb == b_msb) : (a_msb != b_msb);
        return same_sign && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Generic N-bit combinational adder-subtractor: s = a + b or a + ~b + 1.
// cout is bit N of the internal sum, so on subtract it reads 1 = no borrow.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] b_eff;
    logic [N:0]   sum;

    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, op};
    assign s     = sum[N-1:0];
    assign cout  = sum[N];

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator stage around addsub_core. A command is accepted over a
// valid/ready handshake, executed for one cycle against the accumulator, and
// the result is published with carry, overflow and sticky-overflow flags.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_op,
    input  logic         in_clr,
    output logic [N-1:0] acc,
    output logic         cout,
    output logic         ovf,
    output logic         sticky_ovf,
    output logic         out_valid
);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] b_q;
    logic         op_q;
    logic         clr_q;
    logic         accept;
    logic [N-1:0] core_s;
    logic         core_cout;
    logic         ovf_new;

    addsub_core #(.N(N)) u_core (
        .a    (acc),
        .b    (b_q),
        .op   (op_q),
        .s    (core_s),
        .cout (core_cout)
    );

    assign ovf_new = ovf_detect(acc[N-1], b_q[N-1], core_s[N-1], op_q);
    assign accept  = in_valid && in_ready;

    // State register; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; in_ready is held low during reset.
    always_comb begin
        state_next = ST_IDLE;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready   = rst_n;
                state_next = accept ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                in_ready   = rst_n;
                out_valid  = 1'b1;
                state_next = accept ? ST_EXEC : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the command operands at accept so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            op_q  <= OP_ADD;
            clr_q <= 1'b0;
        end else if (accept) begin
            b_q   <= in_data;
            op_q  <= in_op;
            clr_q <= in_clr;
        end
    end

    // Write back the result and flags at the end of EXEC; clr loads and clears flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            sticky_ovf <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (clr_q) begin
                acc        <= b_q;
                cout       <= 1'b0;
                ovf        <= 1'b0;
                sticky_ovf <= 1'b0;
            end else begin
                acc        <= core_s;
                cout       <= core_cout;
                ovf        <= ovf_new;
                sticky_ovf <= sticky_ovf | ovf_new;
            end
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed commands, an
// independent integer reference model and a queue of expected results.
module tb_addsub_accumulator;
    import addsub_pkg::*;

    localparam int N = 12;

    typedef struct packed {
        logic [N-1:0] acc;
        logic         cout;
        logic         ovf;
        logic         sticky;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_op;
    logic         in_clr;
    logic [N-1:0] acc;
    logic         cout;
    logic         ovf;
    logic         sticky_ovf;
    logic         out_valid;

    int   errors;
    int   checks;
    exp_t sb[$];

    logic [N-1:0] model_acc;
    logic         model_cout;
    logic         model_ovf;
    logic         model_sticky;

    addsub_accumulator #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_clr     (in_clr),
        .acc        (acc),
        .cout       (cout),
        .ovf        (ovf),
        .sticky_ovf (sticky_ovf),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: signed/unsigned integer arithmetic, then push the expectation.
    task automatic modelPush(input logic clr, input logic op, input logic [N-1:0] d);
        exp_t e;
        int ua, ub, sa, sbv, res, sum;
        if (clr) begin
            model_acc    = d;
            model_cout   = 1'b0;
            model_ovf    = 1'b0;
            model_sticky = 1'b0;
        end else begin
            ua  = int'(model_acc);
            ub  = int'(d);
            sa  = int'($signed(model_acc));
            sbv = int'($signed(d));
            if (op == OP_ADD) begin
                res        = sa + sbv;
                sum        = ua + ub;
                model_cout = (sum >= (1 << N));
            end else begin
                res        = sa - sbv;
                sum        = ua - ub;
                model_cout = (ua >= ub);
            end
            model_ovf    = (res > (1 << (N - 1)) - 1) || (res < -(1 << (N - 1)));
            model_acc    = sum[N-1:0];
            model_sticky = model_sticky | model_ovf;
        end
        e.acc    = model_acc;
        e.cout   = model_cout;
        e.ovf    = model_ovf;
        e.sticky = model_sticky;
        sb.push_back(e);
    endtask

    // Present a command, wait (bounded) for it to be accepted, then drop in_valid.
    task automatic applyStimulus(input logic clr, input logic op, input logic [N-1:0] d);
        int waited;
        in_valid = 1'b1;
        in_clr   = clr;
        in_op    = op;
        in_data  = d;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        checkValue("accept_ready", 32'(in_ready), 32'd1);
        modelPush(clr, op, d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Pop the oldest expectation and compare it with the published result.
    task automatic popCompare(input string tag);
        exp_t e;
        checkValue({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkValue({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkValue({tag, "_acc"}, 32'(acc), 32'(e.acc));
            checkValue({tag, "_cout"}, 32'(cout), 32'(e.cout));
            checkValue({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            checkValue({tag, "_sticky"}, 32'(sticky_ovf), 32'(e.sticky));
        end
    endtask

    // Called one step after the accept edge: out_valid must arrive exactly one cycle later.
    task automatic checkOutput(input string tag);
        int waited;
        checkValue({tag, "_exec_no_valid"}, 32'(out_valid), 32'd0);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (out_valid !== 1'b1 && waited < 6);
        checkValue({tag, "_latency"}, 32'(waited), 32'd1);
        popCompare(tag);
        @(posedge clk); #1;
        checkValue({tag, "_single_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        model_acc    = '0;
        model_cout   = 1'b0;
        model_ovf    = 1'b0;
        model_sticky = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_op        = OP_ADD;
        in_clr       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst_acc", 32'(acc), 32'd0);
        checkValue("rst_cout", 32'(cout), 32'd0);
        checkValue("rst_ovf", 32'(ovf), 32'd0);
        checkValue("rst_sticky", 32'(sticky_ovf), 32'd0);
        checkValue("rst_out_valid", 32'(out_valid), 32'd0);
        checkValue("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkValue("rst_release_ready", 32'(in_ready), 32'd1);

        // Basic add
        applyStimulus(1'b1, OP_ADD, 12'h07D);
        checkOutput("load_07d");
        applyStimulus(1'b0, OP_ADD, 12'hFBF);
        checkOutput("add_fbf");
        checkValue("add_fbf_acc_const", 32'(acc), 32'h03C);
        checkValue("add_fbf_cout_const", 32'(cout), 32'd1);

        // Positive overflow, then sticky holds across a clean subtract
        applyStimulus(1'b1, OP_ADD, 12'h7FF);
        checkOutput("load_7ff");
        applyStimulus(1'b0, OP_ADD, 12'h001);
        checkOutput("ovf_add");
        checkValue("ovf_add_acc_const", 32'(acc), 32'h800);
        checkValue("ovf_add_ovf_const", 32'(ovf), 32'd1);
        applyStimulus(1'b0, OP_SUB, 12'h000);
        checkOutput("sub_zero");
        checkValue("sub_zero_sticky_const", 32'(sticky_ovf), 32'd1);
        checkValue("sub_zero_ovf_const", 32'(ovf), 32'd0);

        // Borrow path; the load also clears sticky
        applyStimulus(1'b1, OP_ADD, 12'h016);
        checkOutput("load_016");
        checkValue("load_016_sticky_clear", 32'(sticky_ovf), 32'd0);
        applyStimulus(1'b0, OP_SUB, 12'h009);
        checkOutput("sub_009");
        checkValue("sub_009_acc_const", 32'(acc), 32'h00D);
        applyStimulus(1'b0, OP_SUB, 12'h020);
        checkOutput("sub_020");
        checkValue("sub_020_acc_const", 32'(acc), 32'hFED);
        checkValue("sub_020_cout_const", 32'(cout), 32'd0);

        // Back-to-back with in_valid held high
        applyStimulus(1'b1, OP_ADD, 12'h000);
        checkOutput("load_000");
        in_valid = 1'b1;
        in_clr   = 1'b0;
        in_op    = OP_ADD;
        in_data  = 12'h001;
        for (int i = 0; i < 3; i++) begin
            checkValue("b2b_ready_high", 32'(in_ready), 32'd1);
            modelPush(1'b0, OP_ADD, 12'h001);
            @(posedge clk); #1;
            checkValue("b2b_ready_low", 32'(in_ready), 32'd0);
            checkValue("b2b_exec_no_valid", 32'(out_valid), 32'd0);
            if (i == 2) in_valid = 1'b1;
            @(posedge clk); #1;
            popCompare("b2b");
            checkValue("b2b_acc_const", 32'(acc), 32'(i + 1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkValue("b2b_idle_no_valid", 32'(out_valid), 32'd0);

        // Input changes while busy are ignored; the new value is taken at DONE
        in_valid = 1'b1;
        in_data  = 12'h005;
        modelPush(1'b0, OP_ADD, 12'h005);
        @(posedge clk); #1;
        in_data = 12'hABC;
        checkValue("busy_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        popCompare("busy_first");
        checkValue("busy_first_acc_const", 32'(acc), 32'h008);
        modelPush(1'b0, OP_ADD, 12'hABC);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        popCompare("busy_second");
        checkValue("busy_second_acc_const", 32'(acc), 32'hAC4);
        @(posedge clk); #1;

        // Reset in the middle of EXEC abandons the command
        applyStimulus(1'b1, OP_ADD, 12'h123);
        checkOutput("load_123");
        in_valid = 1'b1;
        in_clr   = 1'b0;
        in_op    = OP_ADD;
        in_data  = 12'h001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("midrst_acc", 32'(acc), 32'd0);
        checkValue("midrst_cout", 32'(cout), 32'd0);
        checkValue("midrst_ovf", 32'(ovf), 32'd0);
        checkValue("midrst_sticky", 32'(sticky_ovf), 32'd0);
        checkValue("midrst_ready", 32'(in_ready), 32'd0);
        checkValue("midrst_out_valid", 32'(out_valid), 32'd0);
        model_acc    = '0;
        model_cout   = 1'b0;
        model_ovf    = 1'b0;
        model_sticky = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkValue("postrst_no_valid", 32'(out_valid), 32'd0);
            checkValue("postrst_ready", 32'(in_ready), 32'd1);
        end
        checkValue("postrst_sb_empty", 32'(sb.size()), 32'd0);

        // Normal operation resumes after reset
        applyStimulus(1'b0, OP_ADD, 12'h005);
        checkOutput("postrst_add");
        checkValue("postrst_add_acc_const", 32'(acc), 32'h005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Sequential accumulator stage wrapped around the team's generic N-bit combinational adder-subtractor.
- The accumulator register drives operand A. Operand B and the opcode arrive on a valid/ready input stream.
- Each result S is written back into the accumulator and published with carry and signed-overflow flags.
- Sits directly upstream and downstream of the adder-subtractor: it feeds A/B/Op and consumes S/Cout.

Parameters:
- N, 12, datapath width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  command accepted when in_valid & in_ready at a rising edge.
- in_data  input  N  operand B, or load value when in_clr=1.
- in_op  input  1  0 = add (acc + B), 1 = subtract (acc - B).
- in_clr  input  1  1 = load acc with in_data; in_op is ignored.
- acc  output  N  accumulator value.
- cout  output  1  carry out of the last operation; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow of the last operation.
- sticky_ovf  output  1  OR of ovf since the last clr/reset.
- out_valid  output  1  high for one cycle when acc and the flags reflect a newly completed command.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, cout=0, ovf=0, sticky_ovf=0, out_valid=0. in_ready is forced to 0 while rst_n=0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On accept, register b_q/op_q/clr_q and go to EXEC.
  - EXEC: in_ready=0. Core inputs are A=acc, B=b_q, Op=op_q. At the next edge, write acc/cout/ovf/sticky_ovf and go to DONE.
  - DONE: out_valid=1 and in_ready=1. An accept goes to EXEC (back-to-back); otherwise go to IDLE.
- Latency: accept at edge T0 → acc updated at T0+1 → out_valid high in cycle [T0+1, T0+2).
- Throughput: one command per 2 cycles with in_valid held high.
- Arithmetic: modulo 2^N wrap-around.
  - Subtract is A + ~B + 1; cout is bit N of that sum.
  - ovf on add: sign(A)==sign(B) and sign(S)!=sign(A).
  - ovf on subtract: sign(A)!=sign(B) and sign(S)!=sign(A).
  - sticky_ovf <= sticky_ovf | ovf_new.
- clr command: acc<=in_data, cout<=0, ovf<=0, sticky_ovf<=0. It takes the EXEC path with the same latency and out_valid pulse.
- Input stability: in_data/in_op/in_clr are sampled only at accept. Changes while in_ready=0 have no effect.
- Outputs hold their values between commands. acc changes only at the EXEC→DONE edge.
- Reset mid-EXEC or mid-DONE: the command is abandoned, all outputs return to reset values immediately, and no out_valid follows.
- in_ready returns to 1 in the first cycle after rst_n deasserts (FSM in IDLE).

Decomposition:
- addsub_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2;
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - an overflow-detect function taking (a_msb, b_msb, s_msb, op).
- One sub-module: addsub_core #(N), the existing-style combinational adder-subtractor (A, B, Op, S, Cout), instantiated once.
- FSM, operand registers and flag logic stay in the top level.

Test Plan:
- Basic add: clr load 0x07D, then add 0xFBF → acc=0x03C, cout=1, ovf=0, out_valid one cycle at T0+1.
- Positive overflow: load 0x7FF, add 0x001 → acc=0x800, cout=0, ovf=1, sticky_ovf=1. Then sub 0x000 → acc=0x800, cout=1, ovf=0, sticky_ovf stays 1.
- Borrow path: load 0x016, sub 0x009 → acc=0x00D, cout=1. Then sub 0x020 → acc=0xFED, cout=0, ovf=0.
- Back-to-back: load 0x000, then in_valid held high with three add 0x001 commands → in_ready toggles 1,0,1,0. acc reads 0x001, 0x002, 0x003 with three out_valid pulses 2 cycles apart.
- Input ignored while busy: change in_data to 0xABC during EXEC with in_valid=1 → no effect on the in-flight result; 0xABC is accepted only at the next DONE edge.
- Reset mid-EXEC: accumulate to 0x123, accept add 0x001, pull rst_n low during EXEC → acc=0, flags=0, in_ready=0 immediately. No out_valid after release; in_ready=1 one cycle after rst_n rises.
